// File: rtl/cdc_export_arbiter_pkg.sv
// Shared constants for the export arbiter and its far-domain demux.
// Tag field positions locate the source index inside an exported word.
package cdc_export_arbiter_pkg;

   localparam int unsigned ARB_N    = 4;
   localparam int unsigned ARB_SIZE = 8;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // A single requester still carries a 1-bit tag field.
   function automatic int unsigned idw_of(input int unsigned n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   function automatic int unsigned tag_lsb(input int unsigned size);
      return size;
   endfunction

   function automatic int unsigned tag_msb(input int unsigned idw, input int unsigned size);
      return idw + size - 1;
   endfunction

   localparam int unsigned ARB_IDW = idw_of(ARB_N);
   localparam int unsigned TAG_LSB = tag_lsb(ARB_SIZE);
   localparam int unsigned TAG_MSB = tag_msb(ARB_IDW, ARB_SIZE);

endpackage

// File: rtl/cdc_export_arbiter_rr_pick.sv
// Combinational grant picker over the full[] vector.
// CDC_ARB_FIXED_PRIO_EN selects lowest-index-first instead of round-robin.
module cdc_export_arbiter_rr_pick #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
) (
   input  logic [N-1:0]   full_i,
   input  logic [IDW-1:0] last_i,
   output logic [IDW-1:0] grant_o,
   output logic           any_o
);

`ifdef CDC_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last_i;

   // Descending scan so the lowest full index is the final winner.
   always_comb begin
      grant_o = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         if (full_i[IDW'(k)]) grant_o = IDW'(k);
      end
   end
`else
   logic [IDW-1:0] idx;

   // Scan offsets N..1 from last; the nearest full index after last wins.
   always_comb begin
      grant_o = '0;
      idx     = '0;
      for (int k = int'(N); k >= 1; k--) begin
         idx = IDW'((int'(last_i) + k) % int'(N));
         if (full_i[idx]) grant_o = idx;
      end
   end
`endif

   assign any_o = |full_i;

endmodule

// File: rtl/cdc_export_arbiter.sv
// N one-entry holding buffers drained round-robin into a tagged export channel.
// Define CDC_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module cdc_export_arbiter
   import cdc_export_arbiter_pkg::*;
#(
   parameter int unsigned N    = ARB_N,
   parameter int unsigned SIZE = ARB_SIZE
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N*SIZE-1:0]              req_data,
   input  logic [N-1:0]                   req_stb,
   output logic [N-1:0]                   req_ready,
   output logic [idw_of(N)+SIZE-1:0]      exp_data,
   output logic                           exp_stb,
   input  logic                           exp_ready,
   output logic                           busy
);

   localparam int unsigned IDW  = idw_of(N);
   localparam int unsigned TMSB = tag_msb(IDW, SIZE);
   localparam int unsigned TLSB = tag_lsb(SIZE);

   logic [N-1:0]    full_q, full_d;
   logic [SIZE-1:0] buf_q [N];
   logic [SIZE-1:0] buf_d [N];
   logic [IDW-1:0]  last_q, last_d;
   logic [IDW-1:0]  grant;
   logic            any;

   cdc_export_arbiter_rr_pick #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .full_i  (full_q),
      .last_i  (last_q),
      .grant_o (grant),
      .any_o   (any)
   );

   assign req_ready = ~full_q & {N{~rst}};
   assign busy      = |full_q;
   assign exp_stb   = exp_ready & any;

   // Idle words read as zero so stale buffer contents never leak out.
   always_comb begin
      exp_data = '0;
      if (any) begin
         exp_data[TMSB:TLSB] = grant;
         exp_data[SIZE-1:0]  = buf_q[grant];
      end
   end

   // Capture and drain never share an index: ready is low while full.
   always_comb begin
      full_d = full_q;
      buf_d  = buf_q;
      last_d = last_q;
      for (int i = 0; i < int'(N); i++) begin
         if (req_stb[i] && req_ready[i]) begin
            buf_d[i]  = req_data[i*SIZE +: SIZE];
            full_d[i] = 1'b1;
         end
      end
      if (exp_stb) begin
         full_d[grant] = 1'b0;
`ifndef CDC_ARB_FIXED_PRIO_EN
         last_d = grant;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= '0;
         last_q <= IDW'(N - 1);
         for (int i = 0; i < int'(N); i++) buf_q[i] <= '0;
      end else begin
         full_q <= full_d;
         last_q <= last_d;
         buf_q  <= buf_d;
      end
   end

endmodule

// File: tb/tb_cdc_export_arbiter.sv
// Directed bench for cdc_export_arbiter (N=4, SIZE=8).
module tb_cdc_export_arbiter;
   import cdc_export_arbiter_pkg::*;

   localparam int unsigned N    = ARB_N;
   localparam int unsigned SIZE = ARB_SIZE;
   localparam int unsigned DW   = ARB_IDW + ARB_SIZE;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*SIZE-1:0] req_data = '0;
   logic [N-1:0]    req_stb = '0;
   logic [N-1:0]    req_ready;
   logic [DW-1:0]   exp_data;
   logic            exp_stb;
   logic            exp_ready = 1'b0;
   logic            busy;

   int checks = 0;
   int errors = 0;

   cdc_export_arbiter #(.N(N), .SIZE(SIZE)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_data  (req_data),
      .req_stb   (req_stb),
      .req_ready (req_ready),
      .exp_data  (exp_data),
      .exp_stb   (exp_stb),
      .exp_ready (exp_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic set_data(input int idx, input logic [SIZE-1:0] v);
      req_data[idx*SIZE +: SIZE] = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_stb = '0;
      exp_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
      checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", exp_stb); end
      checks++; if (exp_data !== 10'h000) begin errors++; $display("FAIL reset_data got %h want 000", exp_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL release_ready got %b want 1111", req_ready); end
      checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL release_stb got %b want 0", exp_stb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
   endtask

   task automatic test_single();
      do_reset();
      exp_ready = 1'b1;
      set_data(2, 8'hA5);
      req_stb = 4'b0100;
      #1;
      checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL single_latency got %b want 0", exp_stb); end
      @(negedge clk);
      req_stb = '0;
      #1;
      checks++; if (exp_stb !== 1'b1) begin errors++; $display("FAIL single_stb got %b want 1", exp_stb); end
      checks++; if (exp_data !== 10'h2A5) begin errors++; $display("FAIL single_data got %h want 2a5", exp_data); end
      checks++; if (req_ready !== 4'b1011) begin errors++; $display("FAIL single_ready_full got %b want 1011", req_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL single_ready_drained got %b want 1111", req_ready); end
      checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL single_idle_stb got %b want 0", exp_stb); end
   endtask

   task automatic test_contention();
      logic [DW-1:0] want3, want4;
`ifdef CDC_ARB_FIXED_PRIO_EN
      want3 = 10'h020;
      want4 = 10'h313;
`else
      want3 = 10'h313;
      want4 = 10'h020;
`endif
      do_reset();
      set_data(0, 8'h10);
      set_data(1, 8'h11);
      set_data(3, 8'h13);
      req_stb = 4'b1011;
      @(negedge clk);
      req_stb = '0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL cont_ready got %b want 0100", req_ready); end
      checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL cont_hold_stb got %b want 0", exp_stb); end
      exp_ready = 1'b1;
      #1;
      checks++; if (exp_data !== 10'h010) begin errors++; $display("FAIL cont_grant0 got %h want 010", exp_data); end
      @(negedge clk);
      #1;
      checks++; if (exp_data !== 10'h111) begin errors++; $display("FAIL cont_grant1 got %h want 111", exp_data); end
      set_data(0, 8'h20);
      req_stb = 4'b0001;
      @(negedge clk);
      req_stb = '0;
      #1;
      checks++; if (exp_data !== want3) begin errors++; $display("FAIL cont_grant3 got %h want %h", exp_data, want3); end
      @(negedge clk);
      #1;
      checks++; if (exp_data !== want4) begin errors++; $display("FAIL cont_grant4 got %h want %h", exp_data, want4); end
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_empty got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      do_reset();
      set_data(1, 8'h01);
      req_stb = 4'b0010;
      @(negedge clk);
      req_stb = '0;
      #1;
      checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready_after got %b want 0", req_ready[1]); end
      @(negedge clk);
      set_data(1, 8'h02);
      req_stb = 4'b0010;
      #1;
      checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_ready_second got %b want 0", req_ready[1]); end
      @(negedge clk);
      req_stb = '0;
      exp_ready = 1'b1;
      #1;
      checks++; if (exp_stb !== 1'b1) begin errors++; $display("FAIL bp_stb got %b want 1", exp_stb); end
      checks++; if (exp_data !== 10'h101) begin errors++; $display("FAIL bp_data got %h want 101", exp_data); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL bp_extra_word cycle %0d got %b want 0", c, exp_stb); end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h20 + i));
      req_stb = 4'b1111;
      @(negedge clk);
      req_stb = '0;
      exp_ready = 1'b1;
      #1;
      checks++; if (exp_data !== 10'h020) begin errors++; $display("FAIL ar_pre_grant got %h want 020", exp_data); end
      @(negedge clk);
      exp_ready = 1'b0;
      #2;
      rst = 1'b1;
      exp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL ar_ready got %b want 0000", req_ready); end
      checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL ar_stb got %b want 0", exp_stb); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (exp_stb !== 1'b0) begin errors++; $display("FAIL ar_stale got %b want 0", exp_stb); end
      set_data(0, 8'h30);
      set_data(3, 8'h33);
      req_stb = 4'b1001;
      @(negedge clk);
      req_stb = '0;
      #1;
      checks++; if (exp_data !== 10'h030) begin errors++; $display("FAIL ar_first got %h want 030", exp_data); end
      @(negedge clk);
      #1;
      checks++; if (exp_data !== 10'h333) begin errors++; $display("FAIL ar_second got %h want 333", exp_data); end
   endtask

`ifdef CDC_ARB_FIXED_PRIO_EN
   task automatic test_fixed_prio();
      logic [DW-1:0] d;
      do_reset();
      set_data(1, 8'h51);
      set_data(2, 8'h52);
      req_stb = 4'b0110;
      @(negedge clk);
      req_stb = '0;
      for (int r = 0; r < 4; r++) begin
         exp_ready = 1'b1;
         #1;
         d = exp_data;
         checks++; if (d[TAG_MSB:TAG_LSB] !== 2'd1) begin errors++; $display("FAIL fp_tag round %0d got %0d want 1", r, d[TAG_MSB:TAG_LSB]); end
         @(negedge clk);
         exp_ready = 1'b0;
         if (r < 3) begin
            req_stb = 4'b0010;
         end
         @(negedge clk);
         req_stb = '0;
      end
      exp_ready = 1'b1;
      #1;
      checks++; if (exp_data !== 10'h252) begin errors++; $display("FAIL fp_low_after got %h want 252", exp_data); end
   endtask
`else
   task automatic test_fairness();
      logic [DW-1:0] want;
      do_reset();
      for (int i = 0; i < 4; i++) set_data(i, 8'(8'h40 + i));
      req_stb = 4'b1111;
      @(negedge clk);
      req_stb = '0;
      exp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            set_data((k - 1) % 4, 8'(8'h40 + k + 3));
            req_stb = 4'(1 << ((k - 1) % 4));
         end
         #1;
         want = {2'(k % 4), 8'(8'h40 + k)};
         checks++; if (exp_data !== want) begin errors++; $display("FAIL rr_cycle %0d got %h want %h", k, exp_data, want); end
         @(negedge clk);
         req_stb = '0;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_async_reset();
`ifdef CDC_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_fairness();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
